// File: rtl/if_inst_buffer.sv
// Instruction buffer: circular FIFO of fetch packets between the IF and ID stages.
// Latency: one cycle from push to head (no bypass). Backpressure: fb_allowin is a registered-state "not full" signal.
// Flush empties the buffer on the next edge and suppresses that cycle's push and pop.
module if_inst_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_id_valid,
    input  logic [63:0] if_id_bus,
    output logic        fb_allowin,
    output logic        fb_id_valid,
    output logic [63:0] fb_id_bus,
    input  logic        id_allowin,
    input  logic        flush,
    output logic [4:0]  fb_count
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          push, pop;

    // Handshake outputs look only at registered occupancy, so there is no
    // combinational path from id_allowin or if_id_valid back to fb_allowin.
    assign fb_count    = count_q;
    assign fb_allowin  = (count_q != DEPTH_C);
    assign fb_id_valid = (count_q != 5'd0) & ~flush;
    assign fb_id_bus   = mem_q[rd_ptr_q];

    assign push = if_id_valid & fb_allowin & ~flush;
    assign pop  = fb_id_valid & id_allowin;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 5'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 5'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= if_id_bus;
    end

endmodule

// File: tb/tb_if_inst_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal scenario checks.
module tb_if_inst_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_id_valid;
    logic [63:0] if_id_bus;
    logic        fb_allowin;
    logic        fb_id_valid;
    logic [63:0] fb_id_bus;
    logic        id_allowin;
    logic        flush;
    logic [4:0]  fb_count;

    if_inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_id_valid (if_id_valid),
        .if_id_bus   (if_id_bus),
        .fb_allowin  (fb_allowin),
        .fb_id_valid (fb_id_valid),
        .fb_id_bus   (fb_id_bus),
        .id_allowin  (id_allowin),
        .flush       (flush),
        .fb_count    (fb_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] mq[$];
    bit          model_ok = 0;

    logic [4:0]  s_count;
    logic        s_valid;
    logic        s_allowin;
    logic [63:0] s_bus;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pkt(input logic [31:0] pc, input logic [31:0] inst);
        return {pc, inst};
    endfunction

    // One clock cycle: drive inputs, compare outputs against the queue model, advance the model.
    task automatic cycle(input logic rst, input logic v, input logic [63:0] bus,
                         input logic ida, input logic fl);
        bit exp_valid, do_push, do_pop;
        @(negedge clk);
        reset       = rst;
        if_id_valid = v;
        if_id_bus   = bus;
        id_allowin  = ida;
        flush       = fl;
        #1;
        s_count   = fb_count;
        s_valid   = fb_id_valid;
        s_allowin = fb_allowin;
        s_bus     = fb_id_bus;
        exp_valid = (mq.size() != 0) && !fl;
        if (model_ok) begin
            chk("count",   64'(fb_count),    64'(mq.size()));
            chk("allowin", 64'(fb_allowin),  64'(mq.size() < DEPTH));
            chk("valid",   64'(fb_id_valid), 64'(exp_valid));
            if (exp_valid) chk("bus", fb_id_bus, mq[0]);
        end
        do_push = v && (mq.size() < DEPTH) && !fl;
        do_pop  = exp_valid && ida;
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(bus);
        end
        if (rst) model_ok = 1;
    endtask

    task automatic idle(input logic ida);
        cycle(1'b0, 1'b0, 64'h0, ida, 1'b0);
    endtask

    initial begin
        reset = 1'b1; if_id_valid = 1'b0; if_id_bus = '0; id_allowin = 1'b0; flush = 1'b0;
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

        // Reset state
        idle(1'b0);
        chk("rst_count",   64'(s_count),   64'd0);
        chk("rst_valid",   64'(s_valid),   64'd0);
        chk("rst_allowin", 64'(s_allowin), 64'd1);

        // Fill with ID stalled
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, pkt(32'h1c000000 + 32'(4*i), 32'h00100013 + 32'(i)), 1'b0, 1'b0);
            chk("fill_count_pre", 64'(s_count), 64'(i));
        end
        cycle(1'b0, 1'b1, pkt(32'h1c000010, 32'hdeadbeef), 1'b0, 1'b0);
        chk("fill_count4",  64'(s_count),   64'd4);
        chk("fill_allowin", 64'(s_allowin), 64'd0);
        chk("fill_head",    s_bus,          pkt(32'h1c000000, 32'h00100013));
        idle(1'b0);
        chk("fill_no5th",   64'(s_count),   64'd4);

        // Drain
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("drain_valid", 64'(s_valid), 64'd1);
            chk("drain_pc",    64'(s_bus[63:32]), 64'(32'h1c000000 + 32'(4*i)));
        end
        idle(1'b0);
        chk("drain_valid_end", 64'(s_valid), 64'd0);
        chk("drain_count_end", 64'(s_count), 64'd0);

        // Streaming through an empty buffer, pointers wrap several times
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b1, pkt(32'h1c001000 + 32'(4*k), 32'(k)), 1'b1, 1'b0);
            if (k == 0) begin
                chk("stream_nobypass", 64'(s_valid), 64'd0);
            end else begin
                chk("stream_valid", 64'(s_valid), 64'd1);
                chk("stream_count", 64'(s_count), 64'd1);
                chk("stream_pc",    64'(s_bus[63:32]), 64'(32'h1c001000 + 32'(4*(k-1))));
            end
        end
        idle(1'b1);
        idle(1'b0);

        // Flush with concurrent push
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pkt(32'h1c000020 + 32'(4*i), 32'h1), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, pkt(32'h1c000100, 32'h2), 1'b1, 1'b1);
        chk("flush_pre_count", 64'(s_count), 64'd3);
        chk("flush_valid",     64'(s_valid), 64'd0);
        cycle(1'b0, 1'b1, pkt(32'h1c000200, 32'h3), 1'b1, 1'b0);
        chk("flush_count0",    64'(s_count), 64'd0);
        idle(1'b1);
        chk("flush_next_valid", 64'(s_valid), 64'd1);
        chk("flush_next_pc",    64'(s_bus[63:32]), 64'h1c000200);
        idle(1'b0);
        chk("flush_empty_after", 64'(s_count), 64'd0);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, pkt(32'h1c000300 + 32'(4*i), 32'h4), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, pkt(32'h1c000400, 32'h5), 1'b1, 1'b0);
        chk("fullpop_count",   64'(s_count),   64'd4);
        chk("fullpop_allowin", 64'(s_allowin), 64'd0);
        idle(1'b0);
        chk("fullpop_count3",  64'(s_count),   64'd3);
        chk("fullpop_allowin1", 64'(s_allowin), 64'd1);
        chk("fullpop_head",    64'(s_bus[63:32]), 64'h1c000304);

        // Reset mid-operation
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, pkt(32'h1c000500, 32'h6), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, pkt(32'h1c000504, 32'h7), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pkt(32'h1c000508, 32'h8), 1'b1, 1'b0);
        chk("rstmid_pre_count", 64'(s_count), 64'd2);
        idle(1'b0);
        chk("rstmid_count",   64'(s_count),   64'd0);
        chk("rstmid_valid",   64'(s_valid),   64'd0);
        chk("rstmid_allowin", 64'(s_allowin), 64'd1);

        // Randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  {$urandom, $urandom},
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
